// File: rtl/game_flow_controller.sv
// Starflux phase sequencer: start edge -> START pulse -> PLAY frame scheduling -> OVER; `GAME_PAUSE_EN builds PAUSE.
// All outputs are registered (one cycle after the deciding input); there is no backpressure, the enables are free-running pulses.
module game_flow_controller #(
  parameter int FRAME_TICKS  = 833333,
  parameter int SHIP_DIV     = 2,
  parameter int GRID_DIV     = 1,
  parameter int START_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic       pause,
  input  logic [3:0] ship_health,
  output logic       startGameEn,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       frame_tick,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int FW = $clog2(FRAME_TICKS);
  localparam int SW = (SHIP_DIV > 1) ? $clog2(SHIP_DIV) : 1;
  localparam int GW = (GRID_DIV > 1) ? $clog2(GRID_DIV) : 1;
  localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [SW-1:0] SHIP_LAST  = SW'(SHIP_DIV - 1);
  localparam logic [GW-1:0] GRID_LAST  = GW'(GRID_DIV - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PLAY  = 3'd2,
`ifdef GAME_PAUSE_EN
    PAUSE = 3'd3,
`endif
    OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          start_prev_q, start_prev_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [SW-1:0] ship_div_q, ship_div_d;
  logic [GW-1:0] grid_div_q, grid_div_d;
  logic [CW-1:0] start_cnt_q, start_cnt_d;
  logic          start_game_en_q, start_game_en_d;
  logic          ship_update_en_q, ship_update_en_d;
  logic          grid_update_en_q, grid_update_en_d;
  logic          frame_tick_q, frame_tick_d;
  logic          game_over_q, game_over_d;

  logic start_edge;
  assign start_edge = start_game & ~start_prev_q;

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_comb begin
    state_d          = state_q;
    start_prev_d     = start_game;
    frame_cnt_d      = frame_cnt_q;
    ship_div_d       = ship_div_q;
    grid_div_d       = grid_div_q;
    start_cnt_d      = start_cnt_q;
    start_game_en_d  = 1'b0;
    ship_update_en_d = 1'b0;
    grid_update_en_d = 1'b0;
    frame_tick_d     = 1'b0;

    case (state_q)
      IDLE: if (start_edge) state_d = START;
      START: begin
        // A fresh start edge here is deliberately ignored; the count runs to completion.
        if (start_cnt_q == START_LAST) begin
          state_d = PLAY;
        end else begin
          start_cnt_d     = start_cnt_q + 1'b1;
          start_game_en_d = 1'b1;
        end
      end
      PLAY: begin
        if (start_edge) begin
          state_d = START;
        end else if (ship_health == 4'd0) begin
          state_d = OVER;
        end else begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d  = '0;
            frame_tick_d = 1'b1;
            if (ship_div_q == SHIP_LAST) begin
              ship_div_d       = '0;
              ship_update_en_d = 1'b1;
            end else begin
              ship_div_d = ship_div_q + 1'b1;
            end
            if (grid_div_q == GRID_LAST) begin
              grid_div_d       = '0;
              grid_update_en_d = 1'b1;
            end else begin
              grid_div_d = grid_div_q + 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
`ifdef GAME_PAUSE_EN
          if (pause) state_d = PAUSE;
`endif
        end
      end
`ifdef GAME_PAUSE_EN
      PAUSE: begin
        if (start_edge) state_d = START;
        else if (!pause) state_d = PLAY;
      end
`endif
      OVER: if (start_edge) state_d = START;
      default: state_d = IDLE;
    endcase

    // Every entry into START restarts the pulse count and the frame schedule.
    if (state_d == START && state_q != START) begin
      start_cnt_d     = '0;
      frame_cnt_d     = '0;
      ship_div_d      = '0;
      grid_div_d      = '0;
      start_game_en_d = 1'b1;
    end

    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      start_prev_q     <= 1'b0;
      frame_cnt_q      <= '0;
      ship_div_q       <= '0;
      grid_div_q       <= '0;
      start_cnt_q      <= '0;
      start_game_en_q  <= 1'b0;
      ship_update_en_q <= 1'b0;
      grid_update_en_q <= 1'b0;
      frame_tick_q     <= 1'b0;
      game_over_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      start_prev_q     <= start_prev_d;
      frame_cnt_q      <= frame_cnt_d;
      ship_div_q       <= ship_div_d;
      grid_div_q       <= grid_div_d;
      start_cnt_q      <= start_cnt_d;
      start_game_en_q  <= start_game_en_d;
      ship_update_en_q <= ship_update_en_d;
      grid_update_en_q <= grid_update_en_d;
      frame_tick_q     <= frame_tick_d;
      game_over_q      <= game_over_d;
    end
  end

  assign startGameEn  = start_game_en_q;
  assign shipUpdateEn = ship_update_en_q;
  assign gridUpdateEn = grid_update_en_q;
  assign frame_tick   = frame_tick_q;
  assign game_over    = game_over_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with FRAME_TICKS=10, SHIP_DIV=2, GRID_DIV=3, START_CYCLES=4.
// Outputs are packed as {state[2:0], startGameEn, shipUpdateEn, gridUpdateEn, frame_tick, game_over}.
module tb_game_flow_controller;

  logic       clk;
  logic       reset;
  logic       start_game;
  logic       pause;
  logic [3:0] ship_health;
  logic       startGameEn;
  logic       shipUpdateEn;
  logic       gridUpdateEn;
  logic       frame_tick;
  logic       game_over;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

`ifdef GAME_PAUSE_EN
  localparam int  PAUSE_TICK = 27;
  localparam bit  PAUSE_ON   = 1'b1;
`else
  localparam int  PAUSE_TICK = 20;
  localparam bit  PAUSE_ON   = 1'b0;
`endif

  game_flow_controller #(
    .FRAME_TICKS (10),
    .SHIP_DIV    (2),
    .GRID_DIV    (3),
    .START_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_game  (start_game),
    .pause       (pause),
    .ship_health (ship_health),
    .startGameEn (startGameEn),
    .shipUpdateEn(shipUpdateEn),
    .gridUpdateEn(gridUpdateEn),
    .frame_tick  (frame_tick),
    .game_over   (game_over),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] hp;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [7:0] obs();
    return {state, startGameEn, shipUpdateEn, gridUpdateEn, frame_tick, game_over};
  endfunction

  // Expected outputs at PLAY cycle k (k >= 1) counted from PLAY entry with cleared counters.
  function automatic logic [7:0] exp_play(input int k);
    return {3'd2, 1'b0, 1'((k % 20) == 0), 1'((k % 30) == 0), 1'((k % 10) == 0), 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h ({state,sge,ship,grid,tick,over})", nm, got, exp);
    end
  endtask

  initial begin
    // Start sequence: edge at vec1, a second edge inside START (vec4) must be ignored.
    vecs[0] = '{st: 1'b0, hp: 4'd5, exp: 8'h00, nm: "pre_start"};
    vecs[1] = '{st: 1'b1, hp: 4'd5, exp: 8'h30, nm: "start_n1"};
    vecs[2] = '{st: 1'b1, hp: 4'd5, exp: 8'h30, nm: "start_n2"};
    vecs[3] = '{st: 1'b0, hp: 4'd5, exp: 8'h30, nm: "start_n3"};
    vecs[4] = '{st: 1'b1, hp: 4'd0, exp: 8'h30, nm: "start_n4_edge_ignored"};
    vecs[5] = '{st: 1'b1, hp: 4'd5, exp: 8'h40, nm: "play_entry"};
    vecs[6] = '{st: 1'b0, hp: 4'd5, exp: 8'h40, nm: "play_1"};

    reset       = 1'b0;
    start_game  = 1'b0;
    pause       = 1'b0;
    ship_health = 4'd5;
    step();
    step();
    chk("reset", obs(), 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("idle_%0d", i), obs(), 8'h00);
    end

    for (int i = 0; i < 7; i++) begin
      start_game  = vecs[i].st;
      ship_health = vecs[i].hp;
      step();
      chk(vecs[i].nm, obs(), vecs[i].exp);
    end

    // Frame scheduling up to PLAY cycle 60.
    for (int k = 2; k <= 60; k++) begin
      step();
      chk($sformatf("sched_%0d", k), obs(), exp_play(k));
    end

    // Game over at the terminal count before a ship-update tick (PLAY cycle 80).
    for (int k = 60; k <= 78; k++) begin
      step();
      chk($sformatf("pre_over_%0d", k + 1), obs(), exp_play(k + 1));
    end
    ship_health = 4'd0;
    step();
    chk("over_no_pulse", obs(), 8'h81);
    ship_health = 4'd5;
    step();
    chk("over_hold", obs(), 8'h81);
    start_game = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("over_restart_sge_%0d", i), obs(), 8'h30);
    end
    step();
    chk("over_replay_entry", obs(), 8'h40);
    start_game = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("replay_%0d", k), obs(), exp_play(k));
    end

    // Restart from PLAY with the frame counter at 5.
    for (int k = 30; k <= 44; k++) begin
      step();
      chk($sformatf("pre_restart_%0d", k + 1), obs(), exp_play(k + 1));
    end
    start_game = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("restart_sge_%0d", i), obs(), 8'h30);
    end
    step();
    chk("restart_play_entry", obs(), 8'h40);
    start_game = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("post_restart_%0d", k), obs(), exp_play(k));
    end

    // Pause held on PLAY cycles 15..21 of this run (counter 5 at cycle 15).
    for (int k = 10; k <= 26; k++) begin
      logic [7:0] e;
      int o;
      o = k + 1;
      pause = (k >= 15 && k <= 21);
      step();
      e = 8'h40;
      if (PAUSE_ON && o >= 16 && o <= 22) e[7:5] = 3'd3;
      if (o == PAUSE_TICK) e[3:1] = 3'b101;
      chk($sformatf("pause_%0d", o), obs(), e);
    end
    pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
